// File: rtl/ufm_pkg.sv
// Shared UFM geometry defaults and the burst-reader FSM state encoding.
package ufm_pkg;

    localparam int UFM_ADDR_W = 9;
    localparam int UFM_DATA_W = 16;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_ARM    = 3'd1;
    localparam state_t S_STROBE = 3'd2;
    localparam state_t S_WAIT   = 3'd3;
    localparam state_t S_HOLD   = 3'd4;

endpackage

// File: rtl/ufm_burst_reader_sync2.sv
// Two-flop synchroniser for the asynchronous UFM status lines.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make meta->q a true two-stage shift; blocking would collapse it to one flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ufm_burst_reader.sv
// Back-pressured, timeout-protected burst read engine in front of the UFM primitive.
module ufm_burst_reader
    import ufm_pkg::*;
#(
    parameter int ADDR_W     = UFM_ADDR_W,
    parameter int DATA_W     = UFM_DATA_W,
    parameter int LEN_W      = 4,
    parameter int STROBE_CYC = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              err,
    output logic [ADDR_W-1:0] ufm_addr,
    output logic              ufm_nread,
    output logic              ufm_oscena,
    input  logic              ufm_nbusy,
    input  logic              ufm_dvalid,
    input  logic [DATA_W-1:0] ufm_data
);

    localparam int SC_W = $clog2(STROBE_CYC + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic [SC_W-1:0]   sc_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              nbusy_s;
    logic              dvalid_s;
    logic              dvalid_q;
    logic              dvalid_rise;

    sync2 #(.RST_VAL(1'b1)) u_sync_nbusy (
        .clk (clk),
        .rst (rst),
        .d   (ufm_nbusy),
        .q   (nbusy_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sync_dvalid (
        .clk (clk),
        .rst (rst),
        .d   (ufm_dvalid),
        .q   (dvalid_s)
    );

    assign dvalid_rise = dvalid_s & ~dvalid_q;

    // cmd_ready is gated by rst so a command is never accepted while reset is held.
    assign cmd_ready  = (state == S_IDLE) && !rst;
    assign rsp_valid  = (state == S_HOLD);
    assign rsp_last   = (state == S_HOLD) && (remain_q == '0);
    assign ufm_nread  = (state != S_STROBE);
    assign ufm_oscena = (state != S_IDLE);
    assign ufm_addr   = addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            sc_cnt   <= '0;
            to_cnt   <= '0;
            dvalid_q <= 1'b0;
            rsp_data <= '0;
            err      <= 1'b0;
        end else begin
            err      <= 1'b0;
            dvalid_q <= dvalid_s;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q   <= cmd_addr;
                        remain_q <= cmd_len;
                        state    <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (nbusy_s) begin
                        sc_cnt <= SC_W'(STROBE_CYC - 1);
                        state  <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (sc_cnt == '0) begin
                        to_cnt <= '0;
                        state  <= S_WAIT;
                    end else begin
                        sc_cnt <= sc_cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    // A word that arrives on the final timeout cycle still wins over the abort.
                    if (dvalid_rise) begin
                        rsp_data <= ufm_data;
                        state    <= S_HOLD;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (rsp_ready) begin
                        if (remain_q == '0) begin
                            state <= S_IDLE;
                        end else begin
                            addr_q   <= addr_q + 1'b1;
                            remain_q <= remain_q - 1'b1;
                            state    <= S_ARM;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ufm_burst_reader.sv
// Directed bench for ufm_burst_reader with a behavioural UFM model and a response scoreboard.
module tb_ufm_burst_reader;

    localparam int AW     = 9;
    localparam int DW     = 16;
    localparam int LW     = 4;
    localparam int SC     = 2;
    localparam int TO     = 40;
    localparam int DV_DLY = 2;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;
    logic          err;
    logic [AW-1:0] ufm_addr;
    logic          ufm_nread;
    logic          ufm_oscena;
    logic          ufm_nbusy;
    logic          ufm_dvalid;
    logic [DW-1:0] ufm_data;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] mem [1 << AW];

    int n_cmp   = 0;
    int n_bad   = 0;
    int err_cnt = 0;
    bit model_en = 1'b1;

    ufm_burst_reader #(
        .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .STROBE_CYC(SC), .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .err        (err),
        .ufm_addr   (ufm_addr),
        .ufm_nread  (ufm_nread),
        .ufm_oscena (ufm_oscena),
        .ufm_nbusy  (ufm_nbusy),
        .ufm_dvalid (ufm_dvalid),
        .ufm_data   (ufm_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // UFM model: checks strobe address/width, answers DV_DLY cycles after the strobe ends.
    initial begin : ufm_model
        bit            nread_prev = 1'b1;
        int            low_cnt    = 0;
        int            pend       = 0;
        int            hold       = 0;
        logic [AW-1:0] lat_addr   = '0;
        ufm_dvalid = 1'b0;
        ufm_data   = 16'hDEAD;
        forever begin
            @(negedge clk);
            if (hold > 0) begin
                hold--;
                if (hold == 0) begin
                    ufm_dvalid = 1'b0;
                    ufm_data   = 16'hDEAD;
                end
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    ufm_data   = mem[lat_addr];
                    ufm_dvalid = 1'b1;
                    hold       = 4;
                end
            end
            if (rst) begin
                low_cnt = 0;
                pend    = 0;
            end else if (!ufm_nread) begin
                if (nread_prev) begin
                    low_cnt  = 1;
                    lat_addr = ufm_addr;
                    if (exp_addr_q.size() == 0) check("spurious_strobe", 1, 0);
                    else check("ufm_addr", ufm_addr, exp_addr_q.pop_front());
                end else begin
                    low_cnt++;
                end
            end else if (!nread_prev) begin
                check("strobe_width", low_cnt, SC);
                if (model_en) pend = DV_DLY;
            end
            nread_prev = ufm_nread;
        end
    end

    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (err) begin
                    err_cnt++;
                    check("err_excl_valid", rsp_valid, 0);
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_last", rsp_last, e.last);
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic [AW-1:0] addr, input logic [LW-1:0] len, input bit no_data);
        bit            ok = 1'b0;
        logic [AW-1:0] a;
        rsp_t          e;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("cmd_ready_wait", ok, 1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + AW'(i);
            if (!no_data || i == 0) exp_addr_q.push_back(a);
            if (!no_data) begin
                e.data = mem[a];
                e.last = (i == int'(len));
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("burst_done", ok, 1);
    endtask

    task automatic wait_valid(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("rsp_valid_wait", ok, 1);
    endtask

    task automatic wait_strobe_end(input int budget);
        bit ok   = 1'b0;
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!ufm_nread) seen = 1'b1;
            else if (seen) begin
                ok = 1'b1;
                break;
            end
        end
        check("strobe_end_wait", ok, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_last"}, rsp_last, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_ufm_addr"}, ufm_addr, 0);
        check({tag, "_nread"}, ufm_nread, 1);
        check({tag, "_oscena"}, ufm_oscena, 0);
    endtask

    initial begin : stimulus
        int n;
        int e0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 16'h0123) ^ 16'h5A5A;
        mem[9'h005] = 16'hBEEF;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        rsp_ready = 1'b1;
        ufm_nbusy = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready_after", cmd_ready, 1);

        // Single read with accept-to-strobe latency
        send_cmd(9'h005, 4'd0, 1'b0);
        @(negedge clk);
        check("single_arm_nread", ufm_nread, 1);
        check("single_arm_oscena", ufm_oscena, 1);
        check("single_cmd_ready_busy", cmd_ready, 0);
        @(negedge clk);
        check("single_strobe_lat", ufm_nread, 0);
        wait_done(100);

        // Burst with address wrap and immediate re-arm after each handshake
        send_cmd(9'h1FE, 4'd3, 1'b0);
        wait_valid(100);
        @(posedge clk);
        @(negedge clk);
        check("b2b_valid_drop", rsp_valid, 0);
        check("b2b_arm_oscena", ufm_oscena, 1);
        check("b2b_arm_nread", ufm_nread, 1);
        @(negedge clk);
        check("b2b_strobe", ufm_nread, 0);
        wait_done(200);

        // Back-pressure on word 2 of 3
        send_cmd(9'h100, 4'd2, 1'b0);
        wait_valid(100);
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        wait_valid(100);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_data", rsp_data, exp_q[0].data);
            check("bp_last", rsp_last, 0);
            check("bp_no_strobe", ufm_nread, 1);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_done(200);

        // Timeout abort: model stays silent
        model_en = 1'b0;
        e0 = err_cnt;
        send_cmd(9'h0AA, 4'd2, 1'b1);
        wait_strobe_end(100);
        n = 0;
        for (int i = 0; i < TO + 10; i++) begin
            @(negedge clk);
            n++;
            if (err) break;
        end
        check("timeout_cycles", n, TO);
        repeat (5) @(negedge clk);
        check("timeout_err_once", err_cnt - e0, 1);
        check("timeout_idle_ready", cmd_ready, 1);
        check("timeout_idle_oscena", ufm_oscena, 0);
        model_en = 1'b1;

        // Busy hold-off
        ufm_nbusy = 1'b0;
        repeat (3) @(posedge clk);
        send_cmd(9'h033, 4'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("busy_no_strobe", ufm_nread, 1);
        end
        ufm_nbusy = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (!ufm_nread) break;
        end
        check("busy_release_lat", (n >= 2 && n <= 3), 1);
        wait_done(100);

        // Reset in the middle of WAIT, then a normal read
        model_en = 1'b0;
        send_cmd(9'h020, 4'd0, 1'b1);
        wait_strobe_end(100);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst      = 1'b0;
        model_en = 1'b1;
        @(negedge clk);
        check("midrst_ready_after", cmd_ready, 1);
        send_cmd(9'h010, 4'd0, 1'b0);
        wait_done(100);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("addr_queue_empty", exp_addr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ufm_burst_reader.md
# ufm_burst_reader

Parametrised read controller for the on-chip user flash memory (UFM) block. It accepts burst read requests (start address + word count) on a valid/ready command port and drives the UFM primitive's `addr`/`nread` strobe. It qualifies `nbusy`/`data_valid`, captures each word and streams it out on a valid/ready response port. It replaces free-running strobe generation with a controlled, back-pressured, timeout-protected transaction engine that sits between the UFM primitive and the rest of the design.

## Interface
- `ADDR_W`, default 9: UFM word address width.
- `DATA_W`, default 16: UFM data width.
- `LEN_W`, default 4: burst length field width; a burst is `len+1` words (1..2^LEN_W).
- `STROBE_CYC`, default 2: `ufm_nread` low-pulse width in clocks (>=1).
- `TIMEOUT`, default 1023: max clocks waiting for `data_valid` before abort (>=1).
- `clk` in 1: system clock; UFM status inputs are asynchronous to it.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: burst request present.
- `cmd_ready` out 1: request accepted when both high.
- `cmd_addr` in ADDR_W: first word address.
- `cmd_len` in LEN_W: words minus one.
- `rsp_valid` out 1: `rsp_data` valid.
- `rsp_ready` in 1: consumer accepts word.
- `rsp_data` out DATA_W: captured UFM word.
- `rsp_last` out 1: final word of burst (valid with `rsp_valid`).
- `err` out 1: one-cycle pulse on timeout abort.
- `ufm_addr` out ADDR_W: address to UFM primitive.
- `ufm_nread` out 1: active-low read strobe.
- `ufm_oscena` out 1: UFM oscillator enable, high while not IDLE.
- `ufm_nbusy` in 1: UFM not-busy, async.
- `ufm_dvalid` in 1: UFM data valid, async.
- `ufm_data` in DATA_W: UFM data, stable while `ufm_dvalid` high.

## Operation
- `ufm_nbusy` and `ufm_dvalid` pass through 2-flop synchronisers (reset to 1 and 0). All decisions use the synchronised versions `nbusy_s` and `dvalid_s`.
- States: IDLE, ARM, STROBE, WAIT, HOLD.
- IDLE: `cmd_ready`=1. On accept, latch `addr_q`=`cmd_addr` and `remain_q`=`cmd_len`, then go to ARM.
- ARM: `ufm_oscena`=1. Wait for `nbusy_s`=1, then go to STROBE and load the strobe counter.
- STROBE: drive `ufm_nread`=0 for exactly STROBE_CYC clocks, then go to WAIT and clear the timeout counter.
- WAIT: on the rising edge of `dvalid_s`, capture `ufm_data` into `rsp_data` and go to HOLD.
  - If the timeout counter reaches TIMEOUT first: pulse `err` for 1 cycle, drop the rest of the burst, return to IDLE, and assert no `rsp_valid`.
- HOLD: `rsp_valid`=1, `rsp_last`=(`remain_q`==0). On `rsp_ready`:
  - If last, go to IDLE.
  - Otherwise `addr_q`+=1 and `remain_q`-=1, then go to ARM.
- Address arithmetic is modulo 2^ADDR_W: a burst from all-ones wraps to 0 with no error.
- `ufm_addr` = `addr_q` at all times; it is stable from ARM through WAIT.
- `cmd_ready` is low in every state except IDLE. A command presented mid-burst is held off, not dropped.
- `rsp_data` and `rsp_last` hold stable while `rsp_valid`=1 and `rsp_ready`=0, for any stall length.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 the cycle after; `rsp_valid`=0, `rsp_last`=0, `rsp_data`=0, `err`=0, `ufm_addr`=0, `ufm_nread`=1, `ufm_oscena`=0; state IDLE.
- Reset mid-burst: on the next edge, `ufm_nread` returns to 1 and `rsp_valid` to 0; the burst is discarded.
- Command accept to first `ufm_nread` low: 2 clocks minimum (IDLE→ARM→STROBE), assuming `nbusy_s` is already 1.
- Edge to `rsp_valid`: `ufm_dvalid` rising at the pin reaches `rsp_valid` in 3 clocks (2 sync + capture).
- Back-to-back: with `rsp_ready` tied high, the next word's ARM starts the cycle after the handshake. There is no idle bubble beyond the ARM/STROBE cycles.
- `err` and `rsp_valid` are never high in the same cycle.

## Structure
- Shared package `ufm_pkg`: state enum (IDLE/ARM/STROBE/WAIT/HOLD) and default UFM geometry constants (ADDR_W=9, DATA_W=16).
- One sub-module, `sync2`: a 2-flop synchroniser parametrised by reset value, instantiated twice.
- The rest is flat: FSM, strobe counter, timeout counter, address/remain registers, capture register.

## Test plan
- Single read: `cmd_addr`=0x005, `cmd_len`=0; UFM model returns 0xBEEF → one word 0xBEEF with `rsp_last`=1 and `ufm_nread` low exactly 2 clocks; `cmd_ready` high again after the handshake.
- Burst with wrap: `cmd_addr`=0x1FE, `cmd_len`=3 → `ufm_addr` sequence 0x1FE, 0x1FF, 0x000, 0x001; 4 words in order; `rsp_last` on the 4th only.
- Back-pressure: `rsp_ready` low for 50 cycles on word 2 of 3 → `rsp_data` stable throughout; no new `ufm_nread` strobe until accepted.
- Timeout: the model never raises `data_valid` → `err` pulses once exactly TIMEOUT clocks into WAIT; no `rsp_valid`; IDLE after.
- Busy hold-off: `ufm_nbusy` low for 20 cycles after accept → no strobe until 2 clocks after `ufm_nbusy` rises.
- Reset mid-WAIT: assert `rst` for 1 cycle → all outputs at reset values next edge; a subsequent `cmd_addr`=0x010 read completes normally.
